// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multi-cycle controller: FSM state codes, the
// opcodes the controller understands and the alu_op encodings it drives.
// ---------------------------------------------------------------------------
package ctrl_pkg;

  // State codes are part of the external interface (the state output).
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_R   = 4'd7,
    S_WB_MEM = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10
  } state_t;

  // instr[31:26] opcodes
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  // alu_op encodings
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;

endpackage

// File: rtl/control_multiciclo_if.sv
// ---------------------------------------------------------------------------
// control_multiciclo_if
// Bundle between the multi-cycle controller and its datapath.
//   datapath -> controller : op[5:0], zf, mem_ack
//   controller -> datapath : enables/selects, alu_op[2:0], state[3:0],
//                            illegal_op, mem_err, retired[15:0]
// modport master : the controller side
// modport slave  : the datapath (or testbench) side
// ---------------------------------------------------------------------------
interface control_multiciclo_if;
  logic [5:0]  op;
  logic        zf;
  logic        mem_ack;

  logic        pc_write;
  logic        ir_write;
  logic        reg_write;
  logic        reg_dst;
  logic        alu_src;
  logic        mem_to_reg;
  logic        mem_read;
  logic        mem_write;
  logic        pc_src_branch;
  logic        pc_src_jump;
  logic [2:0]  alu_op;
  logic [3:0]  state;
  logic        illegal_op;
  logic        mem_err;
  logic [15:0] retired;

  modport master (
    input  op, zf, mem_ack,
    output pc_write, ir_write, reg_write, reg_dst, alu_src, mem_to_reg,
           mem_read, mem_write, pc_src_branch, pc_src_jump, alu_op, state,
           illegal_op, mem_err, retired
  );

  modport slave (
    output op, zf, mem_ack,
    input  pc_write, ir_write, reg_write, reg_dst, alu_src, mem_to_reg,
           mem_read, mem_write, pc_src_branch, pc_src_jump, alu_op, state,
           illegal_op, mem_err, retired
  );
endinterface

// File: rtl/control_multiciclo_decodificador_op.sv
// ---------------------------------------------------------------------------
// decodificador_op
// Purely combinational opcode decode for the controller.
//   op          : instruction opcode
//   dec_next    : state to take after DECODE
//   dec_illegal : opcode is not one of R/ADDI/LW/SW/BEQ/J
//   mem_next    : state to take after ADDR (MEM_RD for lw, MEM_WR for sw)
//   mem_illegal : op is neither lw nor sw while in ADDR
// ---------------------------------------------------------------------------
module decodificador_op
  import ctrl_pkg::*;
(
  input  logic [5:0] op,
  output state_t     dec_next,
  output logic       dec_illegal,
  output state_t     mem_next,
  output logic       mem_illegal
);

  always_comb begin
    dec_next    = S_FETCH;
    dec_illegal = 1'b0;
    case (op)
      OP_R:         dec_next = S_EXEC_R;
      OP_ADDI:      dec_next = S_EXEC_I;
      OP_LW, OP_SW: dec_next = S_ADDR;
      OP_BEQ:       dec_next = S_BRANCH;
      OP_J:         dec_next = S_JUMP;
      default:      dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    mem_next    = S_FETCH;
    mem_illegal = 1'b0;
    if (op == OP_LW)      mem_next = S_MEM_RD;
    else if (op == OP_SW) mem_next = S_MEM_WR;
    else                  mem_illegal = 1'b1;
  end

endmodule

// File: rtl/control_multiciclo.sv
// ---------------------------------------------------------------------------
// control_multiciclo
// Moore multi-cycle controller for a small MIPS-like datapath.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : control_multiciclo_if.master (op/zf/mem_ack in, controls out)
// Parameter MEM_TIMEOUT: cycles spent in MEM_RD/MEM_WR without mem_ack
// before the access is abandoned and mem_err is raised.
// ---------------------------------------------------------------------------
module control_multiciclo
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  control_multiciclo_if.master  bus
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MEM_TIMEOUT);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic [15:0]       retired_reg, retired_next;
  logic              illegal_reg, illegal_next;
  logic              mem_err_reg, mem_err_next;
  logic              imm_path_reg, imm_path_next;
  logic              zf_reg;

  state_t            dec_next, mem_next;
  logic              dec_illegal, mem_illegal;
  logic [CNT_W-1:0]  wait_inc;
  logic              wait_expired;

  decodificador_op u_dec (
    .op          (bus.op),
    .dec_next    (dec_next),
    .dec_illegal (dec_illegal),
    .mem_next    (mem_next),
    .mem_illegal (mem_illegal)
  );

  // The cycle whose increment would reach MEM_TIMEOUT is the last chance;
  // an ack on that same cycle still wins.
  assign wait_inc     = wait_cnt_reg + CNT_W'(1);
  assign wait_expired = (wait_inc == WAIT_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_FETCH;
      wait_cnt_reg <= '0;
      retired_reg  <= '0;
      illegal_reg  <= 1'b0;
      mem_err_reg  <= 1'b0;
      imm_path_reg <= 1'b0;
      zf_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      retired_reg  <= retired_next;
      illegal_reg  <= illegal_next;
      mem_err_reg  <= mem_err_next;
      imm_path_reg <= imm_path_next;
      // zf is registered so no output depends combinationally on it; in
      // BRANCH this holds the compare result presented during DECODE.
      zf_reg       <= bus.zf;
    end
  end

  always_comb begin
    state_next    = S_FETCH;
    wait_cnt_next = wait_cnt_reg;
    retired_next  = retired_reg;
    illegal_next  = illegal_reg;
    mem_err_next  = mem_err_reg;
    imm_path_next = imm_path_reg;
    case (state_reg)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        state_next = dec_next;
        if (dec_illegal) illegal_next = 1'b1;
      end
      S_EXEC_R: begin
        state_next    = S_WB_R;
        imm_path_next = 1'b0;
      end
      S_EXEC_I: begin
        state_next    = S_WB_R;
        imm_path_next = 1'b1;
      end
      S_ADDR: begin
        state_next = mem_next;
        if (mem_illegal) illegal_next = 1'b1;
      end
      S_MEM_RD: begin
        if (bus.mem_ack) begin
          state_next = S_WB_MEM;
        end else if (wait_expired) begin
          state_next   = S_FETCH;
          mem_err_next = 1'b1;
        end else begin
          state_next    = S_MEM_RD;
          wait_cnt_next = wait_inc;
        end
      end
      S_MEM_WR: begin
        if (bus.mem_ack) begin
          state_next   = S_FETCH;
          retired_next = retired_reg + 16'd1;
        end else if (wait_expired) begin
          state_next   = S_FETCH;
          mem_err_next = 1'b1;
        end else begin
          state_next    = S_MEM_WR;
          wait_cnt_next = wait_inc;
        end
      end
      S_WB_R, S_WB_MEM, S_BRANCH, S_JUMP: begin
        state_next   = S_FETCH;
        retired_next = retired_reg + 16'd1;
      end
      default: state_next = S_FETCH;
    endcase
    // Counter is held at zero outside the memory states, so it is clear on entry.
    if (state_next != S_MEM_RD && state_next != S_MEM_WR) wait_cnt_next = '0;
  end

  logic       pc_write, ir_write, reg_write, reg_dst, alu_src, mem_to_reg;
  logic       mem_read, mem_write, pc_src_branch, pc_src_jump;
  logic [2:0] alu_op;

  // Moore decode of the registered state; reset blanks the strobes at once
  // because the FETCH state itself would otherwise assert pc_write/ir_write.
  always_comb begin
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    alu_src       = 1'b0;
    mem_to_reg    = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    pc_src_branch = 1'b0;
    pc_src_jump   = 1'b0;
    alu_op        = ALU_ADD;
    if (!reset) begin
      case (state_reg)
        S_FETCH: begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
        S_EXEC_R: alu_op = ALU_FUNCT;
        S_EXEC_I: alu_src = 1'b1;
        S_ADDR:   alu_src = 1'b1;
        S_MEM_RD: mem_read = 1'b1;
        S_MEM_WR: mem_write = 1'b1;
        S_WB_R: begin
          reg_write = 1'b1;
          reg_dst   = ~imm_path_reg;
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_BRANCH: begin
          alu_op        = ALU_SUB;
          pc_write      = zf_reg;
          pc_src_branch = zf_reg;
        end
        S_JUMP: begin
          pc_write    = 1'b1;
          pc_src_jump = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.pc_write      = pc_write;
  assign bus.ir_write      = ir_write;
  assign bus.reg_write     = reg_write;
  assign bus.reg_dst       = reg_dst;
  assign bus.alu_src       = alu_src;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.pc_src_branch = pc_src_branch;
  assign bus.pc_src_jump   = pc_src_jump;
  assign bus.alu_op        = alu_op;
  assign bus.state         = state_reg;
  assign bus.illegal_op    = illegal_reg;
  assign bus.mem_err       = mem_err_reg;
  assign bus.retired       = retired_reg;

endmodule

// File: tb/tb_control_multiciclo.sv
// ---------------------------------------------------------------------------
// tb_control_multiciclo
// Directed bench for control_multiciclo (MEM_TIMEOUT = 4). Outputs are
// sampled on the falling edge; inputs change right after sampling.
// ctl packs {pc_write, ir_write, reg_write, reg_dst, alu_src, mem_to_reg,
//            mem_read, mem_write, pc_src_branch, pc_src_jump}.
// ---------------------------------------------------------------------------
module tb_control_multiciclo;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  control_multiciclo_if bus ();

  control_multiciclo #(.MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] ctl;
  assign ctl = {bus.pc_write, bus.ir_write, bus.reg_write, bus.reg_dst,
                bus.alu_src, bus.mem_to_reg, bus.mem_read, bus.mem_write,
                bus.pc_src_branch, bus.pc_src_jump};

  localparam logic [9:0] C_NONE   = 10'b0000000000;
  localparam logic [9:0] C_FETCH  = 10'b1100000000;
  localparam logic [9:0] C_WB_R   = 10'b0011000000;
  localparam logic [9:0] C_WB_I   = 10'b0010000000;
  localparam logic [9:0] C_ASRC   = 10'b0000100000;
  localparam logic [9:0] C_MRD    = 10'b0000001000;
  localparam logic [9:0] C_MWR    = 10'b0000000100;
  localparam logic [9:0] C_WB_MEM = 10'b0010010000;
  localparam logic [9:0] C_BR_TK  = 10'b1000000010;
  localparam logic [9:0] C_JUMP   = 10'b1000000001;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_now(input string tag, input logic [3:0] st, input logic [9:0] c, input logic [2:0] alu);
    check_eq({tag, ".state"}, 32'(bus.state), 32'(st));
    check_eq({tag, ".ctl"}, 32'(ctl), 32'(c));
    check_eq({tag, ".alu"}, 32'(bus.alu_op), 32'(alu));
    $display("t=%0t %s state=%0d ctl=%b alu=%b retired=%h ill=%b err=%b",
             $time, tag, bus.state, ctl, bus.alu_op, bus.retired, bus.illegal_op, bus.mem_err);
  endtask

  task automatic step(input string tag, input logic [3:0] st, input logic [9:0] c, input logic [2:0] alu);
    @(negedge clk);
    chk_now(tag, st, c, alu);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.op = 6'b000000;
    bus.zf = 1'b0;
    bus.mem_ack = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    chk_now("rst", 4'd0, C_NONE, 3'b000);
    check_eq("rst.retired", 32'(bus.retired), 32'h0);
    check_eq("rst.illegal", 32'(bus.illegal_op), 32'h0);
    check_eq("rst.mem_err", 32'(bus.mem_err), 32'h0);
    reset = 1'b0;
    #1;
    chk_now("r.fetch", 4'd0, C_FETCH, 3'b000);

    // R-type: 0,1,2,7,0
    bus.op = 6'b000000;
    step("r.dec",   4'd1, C_NONE, 3'b000);
    step("r.exec",  4'd2, C_NONE, 3'b010);
    step("r.wb",    4'd7, C_WB_R, 3'b000);
    step("r.fetch2",4'd0, C_FETCH, 3'b000);
    check_eq("r.retired", 32'(bus.retired), 32'd1);

    // addi with a stray mem_ack held high (must be ignored)
    bus.op = 6'b001000;
    bus.mem_ack = 1'b1;
    step("i.dec",   4'd1, C_NONE, 3'b000);
    step("i.exec",  4'd3, C_ASRC, 3'b000);
    step("i.wb",    4'd7, C_WB_I, 3'b000);
    step("i.fetch", 4'd0, C_FETCH, 3'b000);
    bus.mem_ack = 1'b0;
    check_eq("i.retired", 32'(bus.retired), 32'd2);

    // lw, ack on the 4th MEM_RD cycle (the cycle the counter hits the limit)
    bus.op = 6'b100011;
    step("lw.dec",  4'd1, C_NONE, 3'b000);
    step("lw.addr", 4'd4, C_ASRC, 3'b000);
    step("lw.m0",   4'd5, C_MRD, 3'b000);
    step("lw.m1",   4'd5, C_MRD, 3'b000);
    step("lw.m2",   4'd5, C_MRD, 3'b000);
    step("lw.m3",   4'd5, C_MRD, 3'b000);
    bus.mem_ack = 1'b1;
    step("lw.wb",   4'd8, C_WB_MEM, 3'b000);
    bus.mem_ack = 1'b0;
    step("lw.fetch",4'd0, C_FETCH, 3'b000);
    check_eq("lw.retired", 32'(bus.retired), 32'd3);
    check_eq("lw.mem_err", 32'(bus.mem_err), 32'h0);

    // beq taken then not taken
    bus.op = 6'b000100;
    bus.zf = 1'b1;
    step("b1.dec",  4'd1, C_NONE, 3'b000);
    step("b1.br",   4'd9, C_BR_TK, 3'b001);
    step("b1.fetch",4'd0, C_FETCH, 3'b000);
    bus.zf = 1'b0;
    step("b0.dec",  4'd1, C_NONE, 3'b000);
    step("b0.br",   4'd9, C_NONE, 3'b001);
    step("b0.fetch",4'd0, C_FETCH, 3'b000);
    check_eq("b.retired", 32'(bus.retired), 32'd5);

    // j
    bus.op = 6'b000010;
    step("j.dec",   4'd1, C_NONE, 3'b000);
    step("j.jump",  4'd10, C_JUMP, 3'b000);
    step("j.fetch", 4'd0, C_FETCH, 3'b000);
    check_eq("j.retired", 32'(bus.retired), 32'd6);

    // sw with no ack: 4 MEM_WR cycles then timeout
    bus.op = 6'b101011;
    step("sw.dec",  4'd1, C_NONE, 3'b000);
    step("sw.addr", 4'd4, C_ASRC, 3'b000);
    for (int i = 0; i < 4; i++) begin
      step($sformatf("sw.w%0d", i), 4'd6, C_MWR, 3'b000);
      check_eq($sformatf("sw.w%0d.err", i), 32'(bus.mem_err), 32'h0);
    end
    step("sw.fetch",4'd0, C_FETCH, 3'b000);
    check_eq("sw.mem_err", 32'(bus.mem_err), 32'h1);
    check_eq("sw.retired", 32'(bus.retired), 32'd6);

    // illegal opcode
    bus.op = 6'b111111;
    step("il.dec",  4'd1, C_NONE, 3'b000);
    check_eq("il.pre", 32'(bus.illegal_op), 32'h0);
    step("il.fetch",4'd0, C_FETCH, 3'b000);
    check_eq("il.flag", 32'(bus.illegal_op), 32'h1);
    check_eq("il.retired", 32'(bus.retired), 32'd6);
    check_eq("il.mem_err", 32'(bus.mem_err), 32'h1);

    // reset pulse in the middle of MEM_RD
    bus.op = 6'b100011;
    step("rr.dec",  4'd1, C_NONE, 3'b000);
    step("rr.addr", 4'd4, C_ASRC, 3'b000);
    step("rr.m0",   4'd5, C_MRD, 3'b000);
    #2 reset = 1'b1;
    #1;
    chk_now("rr.rst", 4'd0, C_NONE, 3'b000);
    check_eq("rr.retired", 32'(bus.retired), 32'h0);
    check_eq("rr.illegal", 32'(bus.illegal_op), 32'h0);
    check_eq("rr.mem_err", 32'(bus.mem_err), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_now("rr.fetch", 4'd0, C_FETCH, 3'b000);
    bus.op = 6'b000010;
    step("rj.dec",  4'd1, C_NONE, 3'b000);
    step("rj.jump", 4'd10, C_JUMP, 3'b000);
    step("rj.fetch",4'd0, C_FETCH, 3'b000);
    check_eq("rj.retired", 32'(bus.retired), 32'd1);

    // retired wrap: preload FFFF, one more j
    force dut.retired_reg = 16'hFFFF;
    #1 release dut.retired_reg;
    #1 check_eq("wr.preload", 32'(bus.retired), 32'h0000FFFF);
    step("wr.dec",  4'd1, C_NONE, 3'b000);
    step("wr.jump", 4'd10, C_JUMP, 3'b000);
    step("wr.fetch",4'd0, C_FETCH, 3'b000);
    check_eq("wr.retired", 32'(bus.retired), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/control_multiciclo.md
CONTROL_MULTICICLO -- requirements
Module: control_multiciclo

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 255, maximum cycles spent waiting for mem_ack before aborting.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op  input  6  opcode field of the held instruction, instr[31:26].
REQ-005 zf  input  1  zero flag from the ALU.
REQ-006 mem_ack  input  1  data memory completion strobe.
REQ-007 pc_write, ir_write, reg_write, reg_dst, alu_src, mem_to_reg, mem_read, mem_write, pc_src_branch, pc_src_jump  output  1 each  datapath enables/selects.
REQ-008 alu_op  output  3  000 add, 001 sub, 010 decode from funct.
REQ-009 state  output  4  current FSM state code.
REQ-010 illegal_op, mem_err  output  1 each  sticky error flags.
REQ-011 retired  output  16  count of completed instructions.

Function
REQ-012 Control outputs SHALL be Moore, decoded from the registered state only; no combinational path from op, zf or mem_ack to any output.
REQ-013 States/codes: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, ADDR 4, MEM_RD 5, MEM_WR 6, WB_R 7, WB_MEM 8, BRANCH 9, JUMP 10; codes 11-15 unused and SHALL go to FETCH.
REQ-014 FETCH: ir_write=1, pc_write=1, alu_op=000; next DECODE.
REQ-015 DECODE by op: 000000->EXEC_R, 001000->EXEC_I, 100011 or 101011->ADDR, 000100->BRANCH, 000010->JUMP; other -> FETCH, set illegal_op.
REQ-016 EXEC_R: alu_src=0, alu_op=010; next WB_R. WB_R: reg_write=1, reg_dst=1, mem_to_reg=0; next FETCH.
REQ-017 EXEC_I: alu_src=1, alu_op=000; next WB_R with reg_dst=0 (path tracked by one internal flag).
REQ-018 ADDR: alu_src=1, alu_op=000; next MEM_RD when op=100011, MEM_WR when op=101011.
REQ-019 MEM_RD: mem_read=1 held until mem_ack; ack -> WB_MEM. WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-020 MEM_WR: mem_write=1 held until mem_ack; ack -> FETCH.
REQ-021 Wait counter SHALL clear on entry to MEM_RD/MEM_WR and increment each non-ack cycle; when it reaches MEM_TIMEOUT without ack, set mem_err, drop strobe, go to FETCH, no register write.
REQ-022 mem_ack outside MEM_RD/MEM_WR SHALL be ignored; ack on the same cycle the counter hits MEM_TIMEOUT SHALL count as success.
REQ-023 BRANCH: alu_op=001, alu_src=0; pc_src_branch=pc_write=1 only if zf=1; next FETCH.
REQ-024 JUMP: pc_src_jump=1, pc_write=1; next FETCH.
REQ-025 retired SHALL increment by 1 on the cycle leaving WB_R, WB_MEM, MEM_WR (ack), BRANCH or JUMP; not on illegal or timeout; wraps FFFF->0000.
REQ-026 Latencies: R/addi 4 cycles, beq 3, j 3, lw 5+wait, sw 4+wait.

Reset
REQ-027 reset SHALL force state=FETCH, all control outputs 0, alu_op=000, retired=0, illegal_op=0, mem_err=0, wait counter=0, immediately and independent of clk.
REQ-028 Reset asserted mid-instruction (incl. MEM_RD/MEM_WR) SHALL abort it with no write strobe and no count; first post-reset edge performs FETCH.
REQ-029 Error flags clear only on reset.

Structure
REQ-030 Shared package ctrl_pkg SHALL hold state codes, opcode constants (R, ADDI, LW, SW, BEQ, J) and alu_op encodings.
REQ-031 Opcode-to-next-state decode SHALL be a sub-module decodificador_op; counters and FSM register stay in control_multiciclo.

Verification
REQ-032 op=000000, mem_ack=0 -> states 0,1,2,7,0; reg_write=1 and reg_dst=1 only in state 7; retired 0->1.
REQ-033 op=100011, mem_ack raised 3 cycles after entering MEM_RD -> mem_read high 4 cycles, WB_MEM with mem_to_reg=1, retired +1.
REQ-034 op=000100, zf=1 then zf=0 -> pc_write in BRANCH first time only; retired +2 total.
REQ-035 op=101011, mem_ack never high, MEM_TIMEOUT=4 -> mem_err=1 after 4 wait cycles, return to FETCH, retired unchanged, mem_write never with reg_write.
REQ-036 op=111111 -> illegal_op=1, FETCH after DECODE; reset pulse mid MEM_RD -> outputs 0 within same cycle, retired=0.
REQ-037 Preload retired=FFFF via 65535 j instructions (or force) plus one more -> retired=0000.
